// File: rtl/xor_tap_descrambler_if.sv
// Handshake bundle for the tap-XOR descrambler: tap-table load channel,
// scrambled-bit input stream and descrambled-bit output stream.
interface xor_tap_descrambler_if #(
    parameter int TAP_W = 8
);
    logic             cfg_start;
    logic             cfg_valid;
    logic [TAP_W-1:0] cfg_tap;
    logic             cfg_ready;
    logic             cfg_err;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_ready;
    logic             synced;

    modport master (
        output cfg_start, cfg_valid, cfg_tap, in_valid, in_bit, out_ready,
        input  cfg_ready, cfg_err, in_ready, out_valid, out_bit, synced
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_tap, in_valid, in_bit, out_ready,
        output cfg_ready, cfg_err, in_ready, out_valid, out_bit, synced
    );
endinterface

// File: rtl/xor_tap_descrambler.sv
// Self-synchronising descrambler: out = in ^ XOR(hist[tap[k]]), where hist holds
// the received (scrambled) bits. Tap table is loaded serially in CONFIG.
module xor_tap_descrambler #(
    parameter int REG_WIDTH   = 16,
    parameter int NUM_OF_TAPS = 15,
    parameter int TAP_W       = 8
) (
    input  logic                  clk,
    input  logic                  res,
    xor_tap_descrambler_if.slave  bus
);
    localparam int CNT_W  = $clog2(NUM_OF_TAPS + 1);
    localparam int SYNC_W = $clog2(REG_WIDTH + 1);

    typedef enum logic {
        S_CONFIG,
        S_RUN
    } state_t;

    state_t                       state;
    state_t                       state_nxt;
    logic [NUM_OF_TAPS*TAP_W-1:0] tap_table;
    logic [REG_WIDTH-1:0]         hist;
    logic [CNT_W-1:0]             tap_cnt;
    logic [SYNC_W-1:0]            sync_cnt;
    logic                         cfg_err_q;
    logic                         out_valid_q;
    logic                         out_bit_q;

    logic cfg_wr;
    logic last_tap;
    logic in_ready;
    logic in_acc;
    logic fb;

    // cfg_start wins over both load and stream traffic in the same cycle.
    always_comb begin
        cfg_wr   = (state == S_CONFIG) && bus.cfg_valid && !bus.cfg_start;
        last_tap = (tap_cnt == CNT_W'(NUM_OF_TAPS - 1));
        in_ready = (state == S_RUN) && (!out_valid_q || bus.out_ready);
        in_acc   = bus.in_valid && in_ready && !bus.cfg_start;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        if (bus.cfg_start) begin
            state_nxt = S_CONFIG;
        end else begin
            case (state)
                S_CONFIG: if (cfg_wr && last_tap) state_nxt = S_RUN;
                S_RUN:    state_nxt = S_RUN;
                default:  state_nxt = S_CONFIG;
            endcase
        end
    end

    // Indices outside the history never match any i, so they contribute 0;
    // duplicates toggle fb twice and cancel.
    always_comb begin
        fb = 1'b0;
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
            for (int i = 0; i < REG_WIDTH; i++) begin
                if (tap_table[k*TAP_W +: TAP_W] == TAP_W'(i)) fb = fb ^ hist[i];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!res) state <= S_CONFIG;
        else      state <= state_nxt;
    end

    // NOTE: the tap table is a small flop array, not a RAM, so it is cleared with
    // everything else; a RUN with a partially stale table would be silent corruption.
    always_ff @(posedge clk) begin
        if (!res || bus.cfg_start) begin
            tap_table   <= '0;
            hist        <= '0;
            tap_cnt     <= '0;
            sync_cnt    <= '0;
            cfg_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
        end else begin
            if (cfg_wr) begin
                for (int k = 0; k < NUM_OF_TAPS; k++) begin
                    if (tap_cnt == CNT_W'(k)) tap_table[k*TAP_W +: TAP_W] <= bus.cfg_tap;
                end
                tap_cnt <= tap_cnt + 1'b1;
                if (bus.cfg_tap >= TAP_W'(REG_WIDTH)) cfg_err_q <= 1'b1;
            end

            if (in_acc) begin
                // History tracks the line bits, not the descrambled output.
                out_bit_q   <= bus.in_bit ^ fb;
                hist        <= {hist[REG_WIDTH-2:0], bus.in_bit};
                out_valid_q <= 1'b1;
                if (sync_cnt != SYNC_W'(REG_WIDTH)) sync_cnt <= sync_cnt + 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = (state == S_CONFIG);
    assign bus.cfg_err   = cfg_err_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.synced    = (sync_cnt == SYNC_W'(REG_WIDTH));
endmodule

// File: tb/tb_xor_tap_descrambler.sv
// Randomised bench for xor_tap_descrambler against a list-of-received-bits model:
// fb is recomputed from the raw received-bit history and the tap list each accept.
module tb_xor_tap_descrambler;
    localparam int RW = 16;
    localparam int NT = 15;
    localparam int TW = 8;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    xor_tap_descrambler_if #(.TAP_W(TW)) bus ();

    xor_tap_descrambler #(
        .REG_WIDTH  (RW),
        .NUM_OF_TAPS(NT),
        .TAP_W      (TW)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    int   taps[NT];
    logic rx[$];
    logic model_ov;
    logic model_out;
    logic model_run;
    int   nacc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        rx.delete();
        model_ov  = 1'b0;
        model_out = 1'b0;
        model_run = 1'b0;
        nacc      = 0;
    endtask

    // Feedback: for each tap t in range, the bit received t+1 accepts ago.
    function automatic logic model_fb();
        logic f = 1'b0;
        for (int k = 0; k < NT; k++) begin
            if (taps[k] < RW && taps[k] < rx.size()) f ^= rx[rx.size() - 1 - taps[k]];
        end
        return f;
    endfunction

    task automatic idle_inputs();
        bus.cfg_start = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_tap   = '0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cfg_ready"}, 32'(bus.cfg_ready), 1);
        check({tag, "_cfg_err"},   32'(bus.cfg_err),   0);
        check({tag, "_in_ready"},  32'(bus.in_ready),  0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check({tag, "_out_bit"},   32'(bus.out_bit),   0);
        check({tag, "_synced"},    32'(bus.synced),    0);
    endtask

    // One clock of stream traffic; checks at the falling edge, model advances at the rising edge.
    task automatic step(input logic v, input logic b, input logic r, output logic acc);
        logic exp_ready;
        bus.in_valid  = v;
        bus.in_bit    = b;
        bus.out_ready = r;
        @(negedge clk);
        exp_ready = model_run && (!model_ov || r);
        check("in_ready",  32'(bus.in_ready),  32'(exp_ready));
        check("out_valid", 32'(bus.out_valid), 32'(model_ov));
        if (model_ov) check("out_bit", 32'(bus.out_bit), 32'(model_out));
        check("synced",    32'(bus.synced),    32'(nacc >= RW));
        acc = v && exp_ready;
        if (acc) begin
            model_out = b ^ model_fb();
            rx.push_back(b);
            nacc++;
        end
        model_ov = acc || (model_ov && !r);
        @(posedge clk);
        #1;
    endtask

    task automatic load_taps(input int t[NT], input logic do_start);
        bit exp_err = 1'b0;
        if (do_start) begin
            bus.cfg_start = 1'b1;
            @(posedge clk);
            #1;
            bus.cfg_start = 1'b0;
        end
        model_clear();
        check("cfg_ready_open", 32'(bus.cfg_ready), 1);
        check("cfg_err_open",   32'(bus.cfg_err),   0);
        for (int k = 0; k < NT; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.cfg_valid = 1'b0;
                @(posedge clk);
                #1;
                check("cfg_ready_gap", 32'(bus.cfg_ready), 1);
            end
            bus.cfg_valid = 1'b1;
            bus.cfg_tap   = TW'(t[k]);
            bus.in_valid  = 1'b1;
            bus.in_bit    = 1'($urandom_range(0, 1));
            if (t[k] >= RW) exp_err = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.cfg_valid = 1'b0;
        bus.in_valid  = 1'b0;
        taps      = t;
        model_run = 1'b1;
        check("cfg_ready_done", 32'(bus.cfg_ready), 0);
        check("cfg_err_done",   32'(bus.cfg_err),   32'(exp_err));
        check("out_valid_done", 32'(bus.out_valid), 0);
    endtask

    task automatic stream(input logic bits[$], input int vpct, input int rpct, input int budget);
        int   idx = 0;
        int   cyc = 0;
        logic acc;
        while (idx < bits.size() && cyc < budget) begin
            step(1'($urandom_range(0, 99) < vpct), bits[idx], 1'($urandom_range(0, 99) < rpct), acc);
            if (acc) idx++;
            cyc++;
        end
        check("stream_all_accepted", 32'(idx), 32'(bits.size()));
        step(1'b0, 1'b0, 1'b1, acc);
    endtask

    function automatic void rand_bits(ref logic q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(1'($urandom_range(0, 1)));
    endfunction

    initial begin
        int          t[NT];
        logic        bits[$];
        logic        acc;
        logic [19:0] pat;
        logic        exp1[4];
        logic        in1[4];

        idle_inputs();
        res = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        res = 1'b1;

        // All taps on index 0: odd count, fb = previous received bit.
        foreach (t[k]) t[k] = 0;
        load_taps(t, 1'b1);
        in1  = '{1'b1, 1'b0, 1'b1, 1'b1};
        exp1 = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, in1[i], 1'b1, acc);
            check("t1_out_bit",   32'(bus.out_bit),   32'(exp1[i]));
            check("t1_out_valid", 32'(bus.out_valid), 1);
        end
        step(1'b0, 1'b0, 1'b1, acc);
        check("t1_synced", 32'(bus.synced), 0);

        // Two index-0 taps cancel, thirteen index-5 taps leave fb = hist[5].
        t[0] = 0;
        t[1] = 0;
        for (int k = 2; k < NT; k++) t[k] = 5;
        load_taps(t, 1'b1);
        pat = 20'h55A3F;
        bits.delete();
        for (int i = 19; i >= 0; i--) bits.push_back(pat[i]);
        stream(bits, 100, 100, 200);

        // Out-of-range tap flags cfg_err and is ignored; fourteen index-0 taps cancel.
        t[0] = 16;
        for (int k = 1; k < NT; k++) t[k] = 0;
        load_taps(t, 1'b1);
        rand_bits(bits, 24);
        stream(bits, 100, 100, 200);

        // cfg_start collides with live stream and cfg traffic: nothing is consumed.
        step(1'b1, 1'b1, 1'b1, acc);
        bus.cfg_start = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_tap   = TW'(3);
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        model_clear();
        check("t5_cfg_ready", 32'(bus.cfg_ready), 1);
        check("t5_out_valid", 32'(bus.out_valid), 0);
        check("t5_synced",    32'(bus.synced),    0);
        check("t5_cfg_err",   32'(bus.cfg_err),   0);
        check("t5_in_ready",  32'(bus.in_ready),  0);
        foreach (t[k]) t[k] = $urandom_range(0, RW - 1);
        load_taps(t, 1'b0);
        rand_bits(bits, 30);
        stream(bits, 100, 100, 200);

        // Backpressure: one accept, then a stall with in_valid held high.
        step(1'b1, 1'b1, 1'b1, acc);
        repeat (6) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, acc);
        rand_bits(bits, 200);
        stream(bits, 70, 60, 2000);

        // Random table, possibly with out-of-range entries, under random flow control.
        foreach (t[k]) t[k] = $urandom_range(0, RW + 3);
        load_taps(t, 1'b1);
        rand_bits(bits, 150);
        stream(bits, 80, 50, 2000);

        // Reset in the middle of a stalled output.
        step(1'b1, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 1'b0, acc);
        res = 1'b0;
        @(posedge clk);
        #1;
        res = 1'b1;
        idle_inputs();
        model_clear();
        check_reset_outputs("t6");
        foreach (t[k]) t[k] = $urandom_range(0, RW - 1);
        load_taps(t, 1'b1);
        rand_bits(bits, 20);
        stream(bits, 90, 90, 200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/xor_tap_descrambler.md
Name: xor_tap_descrambler

Overview:
- Receive-side counterpart of the tap-XOR feedback generator.
- Loads a tap-index table serially, then self-synchronously descrambles a bit stream: each output bit = received bit XOR (XOR of history bits selected by the taps).
- Sits between the serial link receiver and the byte packer. Uses the same tap-table format as the transmit generator: NUM_OF_TAPS bytes, each byte a bit index into a REG_WIDTH history register.

Parameters:
- REG_WIDTH, 16, width of received-bit history register.
- NUM_OF_TAPS, 15, number of tap-index bytes in the table.
- TAP_W, 8, width of one tap index.

Ports:
- clk  input  1  system clock.
- res  input  1  synchronous active-low reset.
- cfg_start  input  1  pulse: enter CONFIG, clear table/history.
- cfg_valid  input  1  cfg_tap is valid this cycle.
- cfg_tap  input  TAP_W  one tap index.
- cfg_ready  output  1  high in CONFIG.
- cfg_err  output  1  sticky: some loaded index >= REG_WIDTH.
- in_valid  input  1  in_bit valid.
- in_bit  input  1  received scrambled bit.
- in_ready  output  1  block accepts in_bit.
- out_valid  output  1  out_bit valid.
- out_bit  output  1  descrambled bit.
- out_ready  input  1  downstream accepts out_bit.
- synced  output  1  REG_WIDTH bits accepted since last clear.

Behaviour:
- Clock and reset: single clock `clk`; reset `res` is synchronous and active-low. All state updates on the rising edge.
- Reset (res=0 at an edge):
  - State -> CONFIG; tap table, history, tap counter and sync counter cleared.
  - Outputs: cfg_ready=1, cfg_err=0, in_ready=0, out_valid=0, out_bit=0, synced=0.
  - Reset mid-operation discards any pending output.
- CONFIG state:
  - cfg_ready=1, in_ready=0.
  - Each cycle with cfg_valid=1: cfg_tap is written to table entry k = tap counter, stored at bits [k*TAP_W +: TAP_W]. Entry 0 is the first byte written.
  - If cfg_tap >= REG_WIDTH, cfg_err is set; the entry is still stored but contributes 0 in RUN.
  - After entry NUM_OF_TAPS-1 is written: -> RUN next cycle, cfg_ready=0.
- RUN state:
  - in_ready = !out_valid | out_ready (one-entry output register, full throughput).
  - Input accept (in_valid & in_ready) at an edge:
    - out_bit <= in_bit ^ fb, where fb = XOR over k of hist[table[k]] using pre-edge hist. Invalid indices contribute 0; duplicate indices cancel pairwise.
    - hist <= {hist[REG_WIDTH-2:0], in_bit}, so the scrambled bit is shifted in, not the output.
    - out_valid <= 1.
    - Sync counter increments, saturating at REG_WIDTH; synced=1 once it reaches REG_WIDTH.
  - Latency: one cycle from accept to out_valid.
  - Output handshake: out_valid & out_ready with no new accept -> out_valid <= 0. Accept in the same cycle as a drain -> out_valid stays 1 with new data. out_bit holds while out_valid=1 and out_ready=0.
- cfg_start:
  - cfg_start=1 in any state -> CONFIG. Clears table, counters, hist, out_valid and synced; clears cfg_err.
  - cfg_start has priority over cfg_valid and in_valid in the same cycle; neither is consumed that cycle.
- cfg_valid in RUN is ignored; in_valid in CONFIG is ignored.

Test Plan:
1. Reset then load 15 taps all = 0 (odd count, fb = hist[0]) -> RUN after 15th byte. Input bits 1,0,1,1 with out_ready=1 -> out_bit 1,1,1,0, each one cycle after accept; synced=0.
2. Load taps {0,0, then 13 x 5} (fb = hist[5]). Stream 20 bits of 0x55A3F -> out_bit matches a software model; synced rises on the 16th accept exactly.
3. Backpressure: with out_ready=0 after the first accept -> in_ready=0, out_valid=1, out_bit held. Later bits are not consumed. Raise out_ready -> streaming resumes with no bit lost or duplicated.
4. Load one tap = 16, rest = 0 -> cfg_err=1 and the index-16 tap contributes 0. Output equals in ^ hist[0] XOR'ed 14 times, i.e. out = in (even count cancels).
5. cfg_start asserted together with in_valid mid-stream -> no accept that cycle; state CONFIG, out_valid=0, synced=0, cfg_err=0.
6. res=0 asserted for one edge mid-stream with out_valid=1 -> all outputs at reset values next cycle, cfg_ready=1.
